// File: rtl/fir_sym_mac.sv
// fir_sym_mac: time-multiplexed symmetric FIR filter.
//
// One tap pair is pre-added and multiplied per cycle, so an output takes
// M = (TAPS+1)/2 MAC cycles plus one cycle to round and saturate. A
// decimation counter lets DECIM-1 samples shift in without starting a
// computation. Coefficients are loaded through a simple write port and are
// frozen while a computation is running.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   sample offered
//   in_data    signed input sample (DW bits)
//   in_ready   block can accept a sample this cycle (IDLE only)
//   coef_we    coefficient write strobe
//   coef_addr  coefficient index 0..M-1
//   coef_data  signed coefficient (CW bits)
//   out_valid  single-cycle pulse, out_data is new
//   out_data   signed filtered, saturated sample (OW bits), held between pulses
//   sat        pulses with out_valid when out_data was clipped

module fir_sym_mac #(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int TAPS  = 63,
    parameter int SHIFT = 22,
    parameter int OW    = 16,
    parameter int DECIM = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [DW-1:0]          in_data,
    output logic                          in_ready,
    input  logic                          coef_we,
    input  logic [$clog2((TAPS+1)/2)-1:0] coef_addr,
    input  logic signed [CW-1:0]          coef_data,
    output logic                          out_valid,
    output logic signed [OW-1:0]          out_data,
    output logic                          sat
);

    localparam int unsigned M    = (TAPS + 1) / 2;
    localparam int          AW   = $clog2(M);
    localparam int          PAW  = DW + 1;                    // pre-add width
    localparam int          PW   = DW + 1 + CW;               // product width
    localparam int          ACCW = DW + 1 + CW + $clog2(M);   // accumulator width
    localparam int          XW   = ((ACCW > OW) ? ACCW : OW) + 1;
    localparam int          DCW  = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [XW-1:0] OMAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [XW-1:0] OMIN = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           k_q, k_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [DCW-1:0]          dec_q, dec_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OW-1:0]    out_data_q, out_data_d;
    logic                    sat_q, sat_d;

    logic signed [DW-1:0]    d_q    [TAPS];
    logic signed [CW-1:0]    coef_q [M];

    logic                    accept;
    logic                    trigger;
    logic                    coef_wr;
    logic signed [DW-1:0]    tap_lo, tap_hi;
    logic signed [CW-1:0]    tap_c;
    logic signed [PAW-1:0]   pre;
    logic signed [PW-1:0]    prod;
    logic signed [ACCW-1:0]  acc_sh;
    logic signed [XW-1:0]    sh_x;
    logic                    clip_hi, clip_lo;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign trigger   = accept && (dec_q == DCW'(DECIM - 1));
    // A triggering accept starts a computation in the same edge, so a write
    // then would land mid-computation; it is dropped instead.
    assign coef_wr   = coef_we && (state_q == IDLE) && !trigger && (32'(coef_addr) < M);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat       = sat_q;

    // Select tap pair k and its coefficient.
    always_comb begin
        tap_lo = '0;
        tap_hi = '0;
        tap_c  = '0;
        for (int unsigned i = 0; i < M; i++) begin
            if (k_q == AW'(i)) begin
                tap_lo = d_q[i];
                tap_hi = d_q[TAPS-1-i];
                tap_c  = coef_q[i];
            end
        end
    end

    // The centre tap has no partner (lo and hi alias the same sample).
    assign pre    = (k_q == AW'(M - 1)) ? PAW'(tap_lo) : PAW'(tap_lo) + PAW'(tap_hi);
    assign prod   = PW'(pre) * PW'(tap_c);

    // Arithmetic shift floors; compare in a width wider than both sides.
    assign acc_sh  = acc_q >>> SHIFT;
    assign sh_x    = XW'(acc_sh);
    assign clip_hi = sh_x > OMAX;
    assign clip_lo = sh_x < OMIN;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        dec_d       = dec_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        sat_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dec_d = trigger ? '0 : dec_q + DCW'(1);
                end
                if (trigger) begin
                    state_d = MAC;
                    acc_d   = '0;
                    k_d     = '0;
                end
            end
            MAC: begin
                acc_d = acc_q + ACCW'(prod);
                k_d   = k_q + AW'(1);
                if (k_q == AW'(M - 1)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                out_valid_d = 1'b1;
                sat_d       = clip_hi || clip_lo;
                if (clip_hi) begin
                    out_data_d = OMAX[OW-1:0];
                end else if (clip_lo) begin
                    out_data_d = OMIN[OW-1:0];
                end else begin
                    out_data_d = sh_x[OW-1:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            dec_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            dec_q       <= dec_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q    <= '{default: '0};
            coef_q <= '{default: '0};
        end else begin
            if (accept) begin
                for (int unsigned i = TAPS - 1; i > 0; i--) begin
                    d_q[i] <= d_q[i-1];
                end
                d_q[0] <= in_data;
            end
            if (coef_wr) begin
                coef_q[coef_addr] <= coef_data;
            end
        end
    end

endmodule

// File: doc/fir_sym_mac.md
FIR_SYM_MAC -- requirements
Module: fir_sym_mac

Interface
REQ-001 Parameter DW, 16, input sample width (signed).
REQ-002 Parameter CW, 16, coefficient width (signed).
REQ-003 Parameter TAPS, 63, filter length; SHALL be odd and at least 3; M = (TAPS+1)/2 unique coefficients.
REQ-004 Parameter SHIFT, 22, arithmetic right shift applied to the accumulator before output.
REQ-005 Parameter OW, 16, output width (signed).
REQ-006 Parameter DECIM, 1, decimation factor (at least 1).
REQ-007 clk  in  1  sole clock; all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 in_valid  in  1  sample offered.
REQ-010 in_data  in  DW  signed sample.
REQ-011 in_ready  out  1  block can accept a sample this cycle.
REQ-012 coef_we  in  1  coefficient write strobe.
REQ-013 coef_addr  in  clog2(M)  coefficient index 0..M-1.
REQ-014 coef_data  in  CW  signed coefficient.
REQ-015 out_valid  out  1  single-cycle pulse, out_data is new.
REQ-016 out_data  out  OW  signed filtered, saturated sample.
REQ-017 sat  out  1  pulses with out_valid when out_data was clipped.

Function
REQ-018 The block SHALL be a symmetric FIR: y = sum over k=0..M-2 of c[k]*(d[k]+d[TAPS-1-k]), plus c[M-1]*d[M-1], where d[0] is the newest sample.
REQ-019 Accept = in_valid && in_ready; on accept, the delay line SHALL shift by one and d[0] SHALL take in_data.
REQ-020 The FSM SHALL have states IDLE, MAC and OUT; in_ready SHALL be 1 only in IDLE.
REQ-021 A decimation counter (0..DECIM-1) SHALL increment on every accept and wrap from DECIM-1 to 0.
REQ-022 Accept with counter below DECIM-1: shift only; the FSM stays in IDLE and no output is produced.
REQ-023 Accept with counter at DECIM-1: IDLE goes to MAC and the accumulator is cleared.
REQ-024 MAC SHALL take exactly M cycles, processing tap index k=0..M-1 (one pre-add and one multiply per cycle) against the updated delay line, then go to OUT.
REQ-025 OUT SHALL last one cycle, assert out_valid, update out_data and sat, then return to IDLE.
REQ-026 Latency: with a triggering accept at edge T, out_valid SHALL be high in the cycle after edge T+M+1; sustained throughput SHALL be one output per M+2 cycles.
REQ-027 Pre-add width SHALL be DW+1; accumulator width SHALL be DW+1+CW+clog2(M), with no internal overflow.
REQ-028 Output SHALL be the accumulator arithmetically shifted right by SHIFT (truncation toward negative infinity), then saturated to the OW-bit range; sat=1 when clipping occurs.
REQ-029 out_data SHALL hold its value between out_valid pulses.
REQ-030 in_valid while in_ready=0 SHALL be ignored: no shift, no counter change, no data loss signalled.
REQ-031 coef_we SHALL write c[coef_addr] only while in IDLE and without a simultaneous triggering accept.
REQ-032 coef_we in any other case SHALL be ignored, so coefficients stay frozen during a computation.
REQ-033 coef_addr of M or greater SHALL be ignored.
REQ-034 A coefficient write and a non-triggering accept in the same cycle SHALL both take effect.

Reset
REQ-035 While rst=1: FSM = IDLE, delay line = 0, all coefficients = 0, accumulator = 0, decimation counter = 0, out_valid = 0, out_data = 0, sat = 0, in_ready = 0.
REQ-036 in_ready SHALL rise in the first cycle after rst is released.
REQ-037 rst asserted mid-MAC SHALL abort the computation and produce no out_valid after release.

Verification
REQ-038 Defaults: c[31]=32767, all other c=0; feed 16384 then zeros, with the block always ready. The 32nd output (impulse counted as 1st) SHALL be 127, all other outputs 0, and sat=0 throughout.
REQ-039 Latency: accept at edge T. out_valid SHALL go high after edge T+33, and in_ready SHALL be low for exactly 33 cycles.
REQ-040 SHIFT=16, all c=32767, 63 samples of 32767: the final output SHALL be 32767 with sat=1. Repeating with -32768 SHALL give -32768 with sat=1.
REQ-041 DECIM=4, continuous in_valid: out_valid SHALL occur only on every 4th accept, and the three accepts in between SHALL complete within three single cycles each.
REQ-042 coef_we during MAC with a changed value SHALL leave the current and the following output equal to the unchanged-coefficient result.
REQ-043 rst pulse 10 cycles into MAC: no out_valid, out_data=0 and all-zero delay line. The next impulse SHALL reproduce zero output because the coefficients have been cleared.
